ztft43_draw_scheduler: RTL

Sequences draw jobs into the TFT 4.3" adapter over its `en`/`iTrigger`/`done` handshake, replacing the fixed step counter at top level. After reset it issues one full-screen static draw. It then services three refresh sources (sine wave, RTC, pulse counter), each raised by an internal period timer or an external request pulse, and arbitrates them round-robin. A per-job watchdog recovers from an adapter that never returns `done`.

---
 rtl/ztft43_draw_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ztft43_draw_scheduler.sv
// Draw-job sequencer for the TFT 4.3" adapter: one static draw after reset, then
// round-robin refresh of wave / RTC / counter panes, with a per-job watchdog.
module ztft43_draw_scheduler #(
  parameter int WAVE_PERIOD = 200_000,
  parameter int RTC_PERIOD  = 20_000_000,
  parameter int CNT_PERIOD  = 2_000_000,
  parameter int TIMEOUT     = 4_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_wave,
  input  logic       req_rtc,
  input  logic       req_cnt,
  input  logic       req_full,
  input  logic       done,
  output logic       en,
  output logic [3:0] trigger,
  output logic       busy,
  output logic       timeout_err
);

  localparam int WAVE_W = (WAVE_PERIOD > 1) ? $clog2(WAVE_PERIOD) : 1;
  localparam int RTC_W  = (RTC_PERIOD  > 1) ? $clog2(RTC_PERIOD)  : 1;
  localparam int CNT_W  = (CNT_PERIOD  > 1) ? $clog2(CNT_PERIOD)  : 1;
  localparam int TO_W   = (TIMEOUT     > 1) ? $clog2(TIMEOUT)     : 1;

  localparam logic [WAVE_W-1:0] WAVE_LAST = WAVE_W'(WAVE_PERIOD - 1);
  localparam logic [RTC_W-1:0]  RTC_LAST  = RTC_W'(RTC_PERIOD - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CNT_PERIOD - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  localparam int P_FULL = 0;
  localparam int P_WAVE = 1;
  localparam int P_RTC  = 2;
  localparam int P_CNT  = 3;

  localparam logic [3:0] JOB_IDLE   = 4'd0;
  localparam logic [3:0] JOB_STATIC = 4'd1;
  localparam logic [3:0] JOB_WAVE   = 4'd2;
  localparam logic [3:0] JOB_RTC    = 4'd3;
  localparam logic [3:0] JOB_CNT    = 4'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RELEASE} state_t;
  typedef enum logic [1:0] {RR_WAVE, RR_RTC, RR_CNT} rr_t;

  state_t state, state_nxt;
  rr_t    last, last_nxt;

  logic [WAVE_W-1:0] wave_tmr;
  logic [RTC_W-1:0]  rtc_tmr;
  logic [CNT_W-1:0]  cnt_tmr;
  logic [TO_W-1:0]   wd, wd_nxt;
  logic              tick_wave, tick_rtc, tick_cnt;

  logic [3:0] pend, set_vec, clr_vec, win;
  logic [3:0] win_code, trig_nxt;
  logic       en_nxt, err_set;

  assign tick_wave = (wave_tmr == WAVE_LAST);
  assign tick_rtc  = (rtc_tmr  == RTC_LAST);
  assign tick_cnt  = (cnt_tmr  == CNT_LAST);

  // Period timers free-run independently of the scheduler state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_tmr <= '0;
      rtc_tmr  <= '0;
      cnt_tmr  <= '0;
    end else begin
      wave_tmr <= tick_wave ? '0 : wave_tmr + WAVE_W'(1);
      rtc_tmr  <= tick_rtc  ? '0 : rtc_tmr  + RTC_W'(1);
      cnt_tmr  <= tick_cnt  ? '0 : cnt_tmr  + CNT_W'(1);
    end
  end

  assign set_vec = {req_cnt | tick_cnt, req_rtc | tick_rtc, req_wave | tick_wave, req_full};

  // Static redraw beats everything; refresh jobs rotate starting after the last grant.
  always_comb begin
    win = '0;
    if (pend[P_FULL]) begin
      win[P_FULL] = 1'b1;
    end else begin
      case (last)
        RR_WAVE: begin
          if      (pend[P_RTC])  win[P_RTC]  = 1'b1;
          else if (pend[P_CNT])  win[P_CNT]  = 1'b1;
          else if (pend[P_WAVE]) win[P_WAVE] = 1'b1;
        end
        RR_RTC: begin
          if      (pend[P_CNT])  win[P_CNT]  = 1'b1;
          else if (pend[P_WAVE]) win[P_WAVE] = 1'b1;
          else if (pend[P_RTC])  win[P_RTC]  = 1'b1;
        end
        default: begin
          if      (pend[P_WAVE]) win[P_WAVE] = 1'b1;
          else if (pend[P_RTC])  win[P_RTC]  = 1'b1;
          else if (pend[P_CNT])  win[P_CNT]  = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    win_code = JOB_IDLE;
    if      (win[P_FULL]) win_code = JOB_STATIC;
    else if (win[P_WAVE]) win_code = JOB_WAVE;
    else if (win[P_RTC])  win_code = JOB_RTC;
    else if (win[P_CNT])  win_code = JOB_CNT;
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    en_nxt    = en;
    trig_nxt  = trigger;
    wd_nxt    = wd;
    clr_vec   = '0;
    err_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        en_nxt   = 1'b0;
        trig_nxt = JOB_IDLE;
        if (|pend) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        en_nxt   = |win;
        trig_nxt = win_code;
        clr_vec  = win;
        wd_nxt   = '0;
        if (win[P_WAVE]) last_nxt = RR_WAVE;
        if (win[P_RTC])  last_nxt = RR_RTC;
        if (win[P_CNT])  last_nxt = RR_CNT;
        state_nxt = (|win) ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        wd_nxt = wd + TO_W'(1);
        // done has priority over a watchdog expiry in the same cycle
        if (done) begin
          en_nxt    = 1'b0;
          trig_nxt  = JOB_IDLE;
          state_nxt = ST_RELEASE;
        end else if (wd == TO_LAST) begin
          en_nxt    = 1'b0;
          trig_nxt  = JOB_IDLE;
          err_set   = 1'b1;
          state_nxt = ST_RELEASE;
        end
      end
      default: begin
        en_nxt   = 1'b0;
        trig_nxt = JOB_IDLE;
        if (!done) state_nxt = ST_IDLE;
      end
    endcase
  end

  // A request landing in the same cycle as its issue survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last        <= RR_CNT;
      pend        <= 4'b0001;
      en          <= 1'b0;
      trigger     <= JOB_IDLE;
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      last        <= last_nxt;
      pend        <= (pend & ~clr_vec) | set_vec;
      en          <= en_nxt;
      trigger     <= trig_nxt;
      wd          <= wd_nxt;
      timeout_err <= timeout_err | err_set;
    end
  end

  assign busy = en;

endmodule
